// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// State encoding, counter sizing and bit-order selection live here so the
// top and any future variants agree on them.
package piso_pkg;

    // Serializer FSM: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the bit counter for a given word width.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    // Pick serial bit number 'pos' out of a zero-extended word.
    // 'last' is DATA_W-1; MSB-first order mirrors the index around it.
    function automatic logic sel_bit(input logic [63:0] word,
                                     input logic [5:0]  pos,
                                     input logic [5:0]  last,
                                     input logic        lsb_first);
        return lsb_first ? word[pos] : word[last - pos];
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register that parks the next word while the current one shifts.
// Latency: a pushed word is visible on o_dat/o_vld the cycle after the push.
// Backpressure: o_rdy drops while the entry is full; a pop frees it at the same edge.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    input  logic         i_pop
);

    logic         r_full;
    logic [W-1:0] r_dat;

    // Capture a word when empty; release it when the serializer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_dat  <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (i_vld && !r_full) begin
            r_full <= 1'b1;
            r_dat  <= i_dat;
        end
    end

    assign o_rdy = !r_full;
    assign o_vld = r_full;
    assign o_dat = r_dat;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: one DATA_W word per handshake, one bit per clk.
// Latency: first bit on ser_out the cycle after accept; a word occupies DATA_W cycles.
// Backpressure: in_ready low while shifting; ser_en low freezes the serial side.
// Optional PISO_PREFETCH_EN adds a one-word holding register for gapless words.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic              busy
);

    localparam int         CW       = cnt_w(DATA_W);
    localparam logic [5:0] LAST_POS = 6'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_word;
    logic [CW-1:0]     r_cnt;
    logic              r_ser_out;
    logic              r_done;

    logic              w_accept;
    logic              w_adv;
    logic              w_last_adv;
    logic              w_next_vld;
    logic [DATA_W-1:0] w_next_dat;

    assign w_accept   = in_valid && in_ready;
    assign w_adv      = (r_state == SHIFT) && ser_en;
    assign w_last_adv = w_adv && (r_cnt == CW'(DATA_W - 1));

`ifdef PISO_PREFETCH_EN
    logic              w_hold_full;
    logic              w_hold_rdy;
    logic              w_hold_push;
    logic              w_hold_pop;
    logic [DATA_W-1:0] w_hold_dat;

    // A word offered while shifting is parked, unless the last bit is
    // leaving this same edge, in which case it goes straight to the shifter.
    assign w_hold_push = w_accept && (r_state == SHIFT) && !w_last_adv;
    assign w_hold_pop  = w_last_adv && w_hold_full;

    piso_hold_reg #(
        .W (DATA_W)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_hold_push),
        .i_dat (in_data),
        .o_rdy (w_hold_rdy),
        .o_vld (w_hold_full),
        .o_dat (w_hold_dat),
        .i_pop (w_hold_pop)
    );

    assign in_ready   = w_hold_rdy;
    assign w_next_vld = ((r_state == IDLE) && w_accept) ||
                        (w_last_adv && (w_hold_full || w_accept));
    assign w_next_dat = w_hold_full ? w_hold_dat : in_data;
`else
    assign in_ready   = (r_state == IDLE);
    assign w_next_vld = w_accept;
    assign w_next_dat = in_data;
`endif

    // FSM, word register, bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_cnt     <= '0;
            r_ser_out <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_next_vld) begin
            r_state   <= SHIFT;
            r_word    <= w_next_dat;
            r_cnt     <= '0;
            r_ser_out <= sel_bit(64'(w_next_dat), 6'd0, LAST_POS, LSB_FIRST);
            r_done    <= 1'b0;
        end else if (w_last_adv) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_cnt     <= '0;
            r_ser_out <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_adv) begin
            r_cnt     <= r_cnt + CW'(1);
            r_ser_out <= sel_bit(64'(r_word), 6'(r_cnt) + 6'd1, LAST_POS, LSB_FIRST);
            r_done    <= (r_cnt == CW'(DATA_W - 2));
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = (r_state == SHIFT);
    assign busy      = (r_state == SHIFT);
    assign done      = r_done;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter that takes one DATA_W-bit word per valid/ready handshake and sends it one bit per clock.
- Successor to the fixed 2-bit serializer; adds configurable width, bit order, a ready backpressure output, a serial-side stall, and a busy flag.
- Sits between the word-level datapath and the single-wire output stage.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..64.
- LSB_FIRST, 1, 1 = bit 0 is sent first, 0 = bit DATA_W-1 is sent first.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  DATA_W  parallel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_en  in  1  serial advance enable; low stalls shifting.
- ser_out  out  1  serial data bit.
- ser_valid  out  1  ser_out carries a valid bit.
- done  out  1  one-cycle pulse with the last bit of a word.
- busy  out  1  a word is being serialized.

Behaviour:
- Reset (asynchronous): state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, done=0, busy=0.
- in_ready is combinational: high in IDLE, low in SHIFT (base build).
- States:
  - IDLE: on accept (in_valid && in_ready) at edge E, load the shift register and drive the first bit on ser_out at E. Set ser_valid=1, busy=1, counter=0, go to SHIFT. The first bit is visible in the cycle after the accept.
  - SHIFT, ser_en=1 and counter<DATA_W-1: advance to the next bit; counter+1.
  - SHIFT, ser_en=1 and counter==DATA_W-1: return to IDLE; ser_out=0, ser_valid=0, busy=0.
  - SHIFT, ser_en=0: hold ser_out, counter and done unchanged. A stall on the last bit holds done high for the stall length. done stays a single pulse per word only when ser_en is high.
- done=1 exactly while the last bit is on ser_out; 0 otherwise.
- Latency:
  - Accept at edge 0: bit k appears after edge k+1, assuming no stalls.
  - Word occupancy is DATA_W cycles.
  - Base build has a minimum gap of 1 idle cycle between words.
- in_valid during SHIFT: ignored, no side effects. The source must hold in_data until in_ready.
- ser_en has no effect in IDLE.
- Counter width is $clog2(DATA_W). The counter never wraps past DATA_W-1.
- Reset mid-word: the word is discarded, outputs return to reset values immediately, and no done pulse is produced.

Optional Feature:
- Macro PISO_PREFETCH_EN.
- Defined:
  - Adds a one-entry holding register; in_ready = !hold_full in either state.
  - In IDLE with hold empty, a word is accepted straight into the shift register.
  - In SHIFT, a word is accepted into hold.
  - On the last-bit advance with hold full, or with a simultaneous accept, the next word's first bit is driven at that same edge. State stays SHIFT and ser_valid/busy stay high, giving gapless back-to-back words.
  - done still pulses once per word.
  - Reset clears hold.
- Undefined: no holding register; behaviour is exactly the base behaviour above.

Decomposition:
- Shared package piso_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the function cnt_w(DATA_W) = $clog2(DATA_W);
  - the bit-select helper for LSB_FIRST/MSB_FIRST ordering.
- One natural sub-module: piso_hold_reg, the one-entry valid/ready holding register. It is instantiated only under PISO_PREFETCH_EN.

Test Plan:
- DATA_W=8, LSB_FIRST=1, send 0xA5 with ser_en=1 -> ser_out=1,0,1,0,0,1,0,1 on cycles 1..8; done high only on cycle 8; in_ready low on cycles 1..8 and high on cycle 9.
- LSB_FIRST=0, send 0xA5 -> ser_out=1,0,1,0,0,1,0,1 (palindrome check); then send 0x80 -> 1 then seven 0s; ser_valid low between words.
- Send 0xF0 (LSB first) and drop ser_en for 3 cycles after the 2nd bit -> ser_out holds 0 for 4 cycles total; done arrives on cycle 11.
- Assert rst during the 4th bit of 0xFF -> ser_out, ser_valid, busy and done are 0 immediately; no done pulse; the next word 0x01 serializes correctly.
- in_valid held high with changing data during SHIFT -> only the first word is sent; the later word is accepted only once in_ready is high.
- PISO_PREFETCH_EN, DATA_W=4, words 0x3 and 0xC offered back-to-back -> 8 consecutive valid bits 1,1,0,0,0,0,1,1; two done pulses on cycles 4 and 8; no idle gap.
